// File: rtl/cnt_cascade_ctrl_pkg.sv
// Shared types and widths for the two-stage counter cascade controller.
// Holds the FSM state enum, stage geometry and the load-value helper.
package cnt_ctrl_pkg;

  localparam int STAGE_W = 4;
  localparam int NSTAGE  = 2;
  localparam int CNT_W   = STAGE_W * NSTAGE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Start value so that all-ones is reached after n+1 counts.
  function automatic logic [CNT_W-1:0] load_val(
    input logic [CNT_W-1:0] n
  );
    return {CNT_W{1'b1}} - n;
  endfunction

endpackage

// File: rtl/cnt_cascade_ctrl_if.sv
// Control/status bundle for cnt_cascade_ctrl: start/stop/period(/reload) in,
// busy/tick/done/count out. reload exists only with CNT_CASCADE_AUTO_RELOAD_EN.
interface cnt_cascade_ctrl_if;
  import cnt_ctrl_pkg::*;

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
`ifdef CNT_CASCADE_AUTO_RELOAD_EN
  logic             reload;
`endif
  logic             busy;
  logic             tick;
  logic             done;
  logic [CNT_W-1:0] count;

`ifdef CNT_CASCADE_AUTO_RELOAD_EN
  modport master (
    output start, stop, period, reload,
    input  busy, tick, done, count
  );
  modport slave (
    input  start, stop, period, reload,
    output busy, tick, done, count
  );
`else
  modport master (
    output start, stop, period,
    input  busy, tick, done, count
  );
  modport slave (
    input  start, stop, period,
    output busy, tick, done, count
  );
`endif

endinterface

// File: rtl/cnt_cascade_ctrl_cnt4_stage.sv
// 4-bit loadable up-counter: async clear, sync load over count, counts on
// ENP&ENT, RCO = all-ones gated by ENT. Ports: clk, rst_n, nload, enp, ent, din, q, rco.
module cnt4_stage
  import cnt_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_nload,
  input  logic               i_enp,
  input  logic               i_ent,
  input  logic [STAGE_W-1:0] i_din,
  output logic [STAGE_W-1:0] o_q,
  output logic               o_rco
);

  logic [STAGE_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_q <= '0;
    else if (!i_nload)
      r_q <= i_din;
    else if (i_enp && i_ent)
      r_q <= r_q + 1'b1;
  end

  assign o_q   = r_q;
  assign o_rco = (&r_q) & i_ent;

endmodule

// File: rtl/cnt_cascade_ctrl.sv
// Sequences two cnt4_stage counters as an 8-bit interval timer (IDLE/LOAD/RUN/DONE).
// Ports: CLK, nCLR (async low), bus (slave). Option: CNT_CASCADE_AUTO_RELOAD_EN.
module cnt_cascade_ctrl
  import cnt_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              nCLR,
  cnt_cascade_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_din;
  logic [CNT_W-1:0] w_count;
  logic             w_nload;
  logic             w_enp;
  logic             w_ent_lo;
  logic             w_ent_hi;
  logic             w_rco_lo;
  logic             w_rco_hi;
  logic             w_full;
  logic             w_tick;
  logic             w_reload;
  logic             w_busy;
  logic             w_done;

`ifdef CNT_CASCADE_AUTO_RELOAD_EN
  assign w_reload = bus.reload;
`else
  assign w_reload = 1'b0;
`endif

  assign w_full = &w_count;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_state  <= IDLE;
      r_period <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start && !bus.stop)
        r_period <= bus.period;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.start && !bus.stop) w_next = LOAD;
      LOAD: w_next = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop)
          w_next = IDLE;
        else if (w_tick && !w_reload)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ENP drops at all-ones so the cascade holds instead of wrapping;
  // ENT stays up so the terminal RCO still ripples out as tick.
  always_comb begin
    w_nload  = 1'b1;
    w_enp    = 1'b0;
    w_ent_lo = 1'b0;
    w_din    = load_val(r_period);
    w_busy   = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: ;
      LOAD: begin
        w_busy = 1'b1;
        if (!bus.stop) w_nload = 1'b0;
      end
      RUN: begin
        w_busy = 1'b1;
        if (!bus.stop) begin
          w_ent_lo = 1'b1;
          w_enp    = !w_full;
          if (w_full && w_reload) w_nload = 1'b0;
        end
      end
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  assign w_ent_hi = w_rco_lo;
  assign w_tick   = w_rco_hi && (r_state == RUN);

  cnt4_stage u_lo (
    .i_clk   (CLK),
    .i_rst_n (nCLR),
    .i_nload (w_nload),
    .i_enp   (w_enp),
    .i_ent   (w_ent_lo),
    .i_din   (w_din[STAGE_W-1:0]),
    .o_q     (w_count[STAGE_W-1:0]),
    .o_rco   (w_rco_lo)
  );

  cnt4_stage u_hi (
    .i_clk   (CLK),
    .i_rst_n (nCLR),
    .i_nload (w_nload),
    .i_enp   (w_enp),
    .i_ent   (w_ent_hi),
    .i_din   (w_din[CNT_W-1:STAGE_W]),
    .o_q     (w_count[CNT_W-1:STAGE_W]),
    .o_rco   (w_rco_hi)
  );

  assign bus.busy  = w_busy;
  assign bus.tick  = w_tick;
  assign bus.done  = w_done;
  assign bus.count = w_count;

endmodule

// File: doc/cnt_cascade_ctrl.md
CNT_CASCADE_CTRL -- requirements
Module: cnt_cascade_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; no parameters (widths fixed in package).
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 nCLR  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request one interval; sampled only in IDLE.
REQ-005 stop  in  1  abort; sampled in LOAD and RUN.
REQ-006 period  in  8  interval length minus one (N); latched on accepted start.
REQ-007 busy  out  1  high in LOAD and RUN.
REQ-008 tick  out  1  one-cycle pulse at terminal count.
REQ-009 done  out  1  one-cycle pulse on one-shot completion.
REQ-010 count  out  8  cascade value {upper stage, lower stage}.

Function
REQ-011 SHALL sequence two 4-bit loadable up-counter stages as an 8-bit cascade via per-stage nLOAD/ENP/ENT/Din.
REQ-012 FSM states: IDLE, LOAD, RUN, DONE.
REQ-013 IDLE: start=1 and stop=0 -> LOAD; period latched into period_q; start ignored in other states.
REQ-014 LOAD (1 cycle): nLOAD=0 both stages, Din = 8'hFF - period_q -> RUN; stop=1 -> IDLE instead, no load.
REQ-015 RUN: lower stage ENP=ENT=1; upper stage ENP=1, ENT=lower RCO; each stage RCO = all-ones AND own ENT.
REQ-016 tick = upper RCO in RUN (count==8'hFF), combinational, high exactly one cycle.
REQ-017 First tick SHALL occur in the (N+1)th RUN cycle; N=0 ticks in the first RUN cycle; N=255 loads 8'h00.
REQ-018 RUN with tick, one-shot: -> DONE; counters hold 8'hFF.
REQ-019 DONE (1 cycle): done=1, busy=0 -> IDLE; start during DONE ignored.
REQ-020 stop=1 in RUN -> IDLE next edge, count holds, no tick/done; stop wins over a simultaneous tick.
REQ-021 count SHALL never wrap 8'hFF -> 8'h00 by increment; leaving 8'hFF only via load or reset.
REQ-022 Lower-to-upper carry in the same cycle: 8'h0F -> 8'h10 in one edge.

Reset
REQ-023 nCLR low SHALL immediately force IDLE, count=8'h00, period_q=0, busy/tick/done=0, regardless of state.
REQ-024 Reset mid-RUN SHALL discard the interval; first edge after release is in IDLE.

Configuration
REQ-025 Macro CNT_CASCADE_AUTO_RELOAD_EN: when defined, input port reload (1 bit) exists.
REQ-026 With macro and reload=1 at tick: stay RUN, nLOAD=0 that cycle with Din=8'hFF - period_q, tick period exactly N+1 cycles, no done.
REQ-027 With macro and reload=0, or without macro: one-shot behaviour per REQ-018; without macro no reload port.

Structure
REQ-028 Package cnt_ctrl_pkg SHALL hold state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3), STAGE_W=4, NSTAGE=2.
REQ-029 Sub-module cnt4_stage: 4-bit loadable counter, async clear, sync load over count, count on ENP&ENT, RCO gated by ENT; instantiated twice.

Verification
REQ-030 Reset: nCLR low mid-RUN at count 8'h37 -> count=8'h00, busy=0 immediately; IDLE after release.
REQ-031 One-shot: period=5, start pulse -> LOAD 8'hFA, tick in 6th RUN cycle, done next cycle, busy low with done.
REQ-032 Carry: period=8'h F0 -> count passes 8'h0F -> 8'h10 in one edge; tick in 241st RUN cycle.
REQ-033 Abort: period=20, stop at 4th RUN cycle -> IDLE, count holds 8'hEE, no tick/done; start during RUN ignored.
REQ-034 Edge periods: period=0 -> tick in first RUN cycle; period=255 -> load 8'h00, tick after 256 cycles.
REQ-035 Auto-reload (macro on): period=3, reload=1 -> ticks every 4 cycles over 5 intervals, no done; stop ends it.
